// File: rtl/sqrt_seq.sv
// Sequential restoring square-root unit: one root bit per clock, valid/ready on both sides.
// Produces floor or round-half-up sqrt of an integer radicand with FRAC_W fractional result bits.
module sqrt_seq #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 8,
  localparam int W2    = ((IN_W + 2 * FRAC_W + 1) / 2) * 2,
  localparam int OUT_W = W2 / 2,
  localparam int ITER  = OUT_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             round_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_exact,
  output logic             busy
);

  localparam int RAD_W = 2 * ITER;
  localparam int REM_W = OUT_W + 3;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [RAD_W-1:0] rad_q, rad_d;
  logic [ITER-1:0]  root_q, root_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rnd_q, rnd_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_exact_q, out_exact_d;

  logic [REM_W-1:0] rem_shift;
  logic [REM_W-1:0] trial;
  logic             take;
  logic [REM_W-1:0] rem_step;
  logic [ITER-1:0]  root_step;
  logic [OUT_W:0]   rnd_val;
  logic [OUT_W-1:0] result;

  // One restoring step: the top two radicand bits feed the remainder each cycle.
  always_comb begin
    rem_shift = (rem_q << 2) | {{(REM_W-2){1'b0}}, rad_q[RAD_W-1 -: 2]};
    trial     = {root_q, 2'b01};
    take      = (rem_shift >= trial);
    rem_step  = take ? (rem_shift - trial) : rem_shift;
    root_step = {root_q[ITER-2:0], take};
    // (Q'+1)>>1 equals (Q'>>1) + Q'[0]; the extra bit flags overflow for saturation.
    rnd_val   = {1'b0, root_step[ITER-1:1]} + {{OUT_W{1'b0}}, root_step[0]};
    if (!rnd_q) begin
      result = root_step[ITER-1:1];
    end else if (rnd_val[OUT_W]) begin
      result = {OUT_W{1'b1}};
    end else begin
      result = rnd_val[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    root_d      = root_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    out_exact_d = out_exact_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rad_d   = {{(RAD_W-IN_W){1'b0}}, in_data} << (2 * FRAC_W + 2);
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = CNT_W'(ITER);
          rnd_d   = round_en;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rad_d  = {rad_q[RAD_W-3:0], 2'b00};
        root_d = root_step;
        rem_d  = rem_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_data_d  = result;
          out_exact_d = (rem_step == '0) && !root_step[0];
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rad_q       <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      rnd_q       <= 1'b0;
      out_data_q  <= '0;
      out_exact_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_exact_q <= out_exact_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_exact = out_exact_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// Bench for sqrt_seq: three configurations (FRAC_W = 8, 0, 4) against an integer-sqrt model.
// Directed cases, reset, handshake corners, random traffic and an exhaustive sweep.
module tb_sqrt_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] in_valid = '0;
  logic [2:0] out_ready = '0;
  logic [7:0] in_data = '0;
  logic round_en = 1'b0;
  logic [2:0] in_ready_a, out_valid_a, out_exact_a, busy_a;
  logic [2:0][11:0] out_data_a;
  logic [2:0][11:0] last_data;
  logic [2:0] last_exact;
  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int FW = (gi == 0) ? 8 : ((gi == 1) ? 0 : 4);
    logic [3+FW:0] od;
    sqrt_seq #(.IN_W(8), .FRAC_W(FW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[gi]), .in_ready(in_ready_a[gi]),
      .in_data(in_data), .round_en(round_en),
      .out_valid(out_valid_a[gi]), .out_ready(out_ready[gi]),
      .out_data(od), .out_exact(out_exact_a[gi]), .busy(busy_a[gi])
    );
    assign out_data_a[gi] = 12'(od);
  end

  function automatic int fw_of(int i);
    if (i == 0) return 8;
    if (i == 1) return 0;
    return 4;
  endfunction

  function automatic int ow_of(int i);
    return 4 + fw_of(i);
  endfunction

  function automatic int iter_of(int i);
    return ow_of(i) + 1;
  endfunction

  function automatic longint isqrt(longint n);
    longint lo = 0;
    longint hi = 64'd1 << 20;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // sqrt(x * 4^FRAC_W) as an integer: floor, or nearest with halves rounded up, clipped to OUT_W bits.
  function automatic void model(int i, int x, bit rnd, output longint d, output bit ex);
    longint n = longint'(x) << (2 * fw_of(i));
    longint t = isqrt(n);
    longint mx = (longint'(1) << ow_of(i)) - 1;
    ex = (t * t == n);
    if (rnd && (n - t * t > t)) t++;
    if (t > mx) t = mx;
    d = t;
  endfunction

  task automatic check(string tag, longint got, longint exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Starts and ends at a falling edge; leaves the request accepted and in_valid low.
  task automatic start_txn(logic [2:0] mask, int x, bit rnd);
    in_data  = 8'(x);
    round_en = rnd;
    in_valid = mask;
    for (int i = 0; i < 3; i++) if (mask[i]) check("accept_ready", in_ready_a[i], 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    for (int i = 0; i < 3; i++) if (mask[i]) check("accept_busy", busy_a[i], 1);
  endtask

  task automatic finish_txn(logic [2:0] mask, int x, bit rnd, int hold, bit disturb,
                            bit b2b, int nx, bit nrnd);
    int lat [3];
    int cnt = 0;
    int unstable = 0;
    bit all_done;
    longint ed;
    bit ee;
    for (int i = 0; i < 3; i++) lat[i] = -1;
    while (cnt <= 40) begin
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (mask[i] && lat[i] < 0 && out_valid_a[i]) lat[i] = cnt;
        if (mask[i] && lat[i] < 0) all_done = 1'b0;
      end
      if (all_done) break;
      if (disturb) begin
        in_valid = mask & 3'($urandom);
        in_data  = 8'($urandom);
        round_en = 1'($urandom);
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    in_valid = '0;
    for (int i = 0; i < 3; i++) if (mask[i]) begin
      model(i, x, rnd, ed, ee);
      check("latency", lat[i], iter_of(i));
      check("data", out_data_a[i], ed);
      check("exact", out_exact_a[i], ee);
      check("ready_low_done", in_ready_a[i], 0);
      last_data[i]  = out_data_a[i];
      last_exact[i] = out_exact_a[i];
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (mask[i] && (!out_valid_a[i] || out_data_a[i] !== last_data[i] ||
                        out_exact_a[i] !== last_exact[i])) unstable++;
    end
    if (hold > 0) check("hold_stable", unstable, 0);
    out_ready = mask;
    if (b2b) begin
      in_valid = mask;
      in_data  = 8'(nx);
      round_en = nrnd;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = '0;
    for (int i = 0; i < 3; i++) if (mask[i]) begin
      check("valid_drop", out_valid_a[i], 0);
      check("ready_rise", in_ready_a[i], 1);
    end
    if (b2b) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = '0;
      for (int i = 0; i < 3; i++) if (mask[i]) check("b2b_accept", busy_a[i], 1);
    end
    $display("txn x=%0d rnd=%0d mask=%b d=%0d/%0d/%0d exact=%b", x, rnd, mask,
             last_data[0], last_data[1], last_data[2], last_exact);
  endtask

  typedef struct {
    int x;
    bit r;
    int d;
    bit e;
  } dir_t;

  dir_t def_tab [6] = '{
    '{x: 2,   r: 1'b0, d: 362,  e: 1'b0},
    '{x: 144, r: 1'b0, d: 3072, e: 1'b1},
    '{x: 0,   r: 1'b0, d: 0,    e: 1'b1},
    '{x: 255, r: 1'b0, d: 4087, e: 1'b0},
    '{x: 255, r: 1'b1, d: 4088, e: 1'b0},
    '{x: 3,   r: 1'b1, d: 443,  e: 1'b0}
  };

  dir_t sat_tab [2] = '{
    '{x: 255, r: 1'b1, d: 15, e: 1'b0},
    '{x: 225, r: 1'b1, d: 15, e: 1'b1}
  };

  initial begin
    int saw;
    int rx;
    bit rr;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", in_ready_a[i], 1);
      check("rst_out_valid", out_valid_a[i], 0);
      check("rst_out_data", out_data_a[i], 0);
      check("rst_out_exact", out_exact_a[i], 0);
      check("rst_busy", busy_a[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a computation discards it.
    start_txn(3'b001, 200, 1'b0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    check("mid_busy", busy_a[0], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid_a[0], 0);
    check("midrst_ready", in_ready_a[0], 1);
    check("midrst_busy", busy_a[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid_a[0]) saw++;
    end
    check("no_stale", saw, 0);
    check("ready_after_rst", in_ready_a[0], 1);

    foreach (def_tab[k]) begin
      start_txn(3'b001, def_tab[k].x, def_tab[k].r);
      finish_txn(3'b001, def_tab[k].x, def_tab[k].r, 0, 1'b0, 1'b0, 0, 1'b0);
      check("spec_data", last_data[0], def_tab[k].d);
      check("spec_exact", last_exact[0], def_tab[k].e);
    end

    foreach (sat_tab[k]) begin
      start_txn(3'b010, sat_tab[k].x, sat_tab[k].r);
      finish_txn(3'b010, sat_tab[k].x, sat_tab[k].r, 0, 1'b0, 1'b0, 0, 1'b0);
      check("sat_data", last_data[1], sat_tab[k].d);
      check("sat_exact", last_exact[1], sat_tab[k].e);
    end

    // Backpressure hold, input noise while busy, then a back-to-back pair.
    start_txn(3'b001, 77, 1'b0);
    finish_txn(3'b001, 77, 1'b0, 20, 1'b0, 1'b0, 0, 1'b0);
    start_txn(3'b001, 50, 1'b1);
    finish_txn(3'b001, 50, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
    start_txn(3'b001, 100, 1'b0);
    finish_txn(3'b001, 100, 1'b0, 0, 1'b0, 1'b1, 169, 1'b0);
    finish_txn(3'b001, 169, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    check("b2b_value", last_data[0], 3328);

    repeat (60) begin
      rx = int'($urandom_range(0, 255));
      rr = 1'($urandom);
      start_txn(3'b111, rx, rr);
      finish_txn(3'b111, rx, rr, int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 0, 1'b0);
    end

    for (int r = 0; r < 2; r++) begin
      for (int x = 0; x < 256; x++) begin
        start_txn(3'b111, x, 1'(r));
        finish_txn(3'b111, x, 1'(r), 0, 1'b0, 1'b0, 0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
